// File: rtl/updown_counter_disp_pkg.sv
// updown_counter_disp_pkg: 7-segment glyphs (bit order gfedcba) and segment bit positions
package updown_counter_disp_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_0 = 7'h3f;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5b;
  localparam logic [6:0] SEG_3 = 7'h4f;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6d;
  localparam logic [6:0] SEG_6 = 7'h7d;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7f;
  localparam logic [6:0] SEG_9 = 7'h6f;
  localparam logic [6:0] SEG_HA = 7'h77;
  localparam logic [6:0] SEG_HB = 7'h7c;
  localparam logic [6:0] SEG_HC = 7'h39;
  localparam logic [6:0] SEG_HD = 7'h5e;
  localparam logic [6:0] SEG_HE = 7'h79;
  localparam logic [6:0] SEG_HF = 7'h71;
endpackage

// File: rtl/updown_counter_disp_seg7.sv
// seg7_hex_decode: combinational hex nibble to active-high segment pattern
module seg7_hex_decode
  import updown_counter_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'ha: seg = SEG_HA;
      4'hb: seg = SEG_HB;
      4'hc: seg = SEG_HC;
      4'hd: seg = SEG_HD;
      4'he: seg = SEG_HE;
      default: seg = SEG_HF;
    endcase
  end
endmodule

// File: rtl/updown_counter_disp.sv
// updown_counter_disp: up/down counter with load, modulus, wrap/saturate and scanned hex display
module updown_counter_disp
  import updown_counter_disp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int SATURATE = 0,
  parameter int SCAN_DIV = 4,
  localparam int NDIG    = (WIDTH + 3) / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [NDIG-1:0]  digit
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  logic dir, hi, lo, tick, nxt_tc;
  logic [WIDTH-1:0] nxt;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [4*NDIG-1:0] wide;
  logic [3:0] nib;
  logic [6:0] glyph;
  // an out-of-range count is a limit step in either direction
  assign hi = out >= MAXV;
  assign lo = out == '0 || out > MAXV;
  assign tick = presc == PW'(SCAN_DIV - 1);
  assign wide = (4*NDIG)'(out);
  assign nib = wide[4*idx +: 4];
  always_comb begin
    nxt = out;
    nxt_tc = 1'b0;
    if (load) nxt = load_val > MAXV ? MAXV : load_val;
    else if (en && updown) begin
      nxt = hi ? (SATURATE != 0 ? out : '0) : out + 1'b1;
      nxt_tc = hi;
    end else if (en) begin
      nxt = lo ? (SATURATE != 0 ? out : MAXV) : out - 1'b1;
      nxt_tc = lo;
    end
  end
  seg7_hex_decode u_dec (.hex(nib), .seg(glyph));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
      tc <= 1'b0;
      seg <= '0;
      dp <= 1'b0;
      digit <= '0;
      dir <= 1'b1;
      idx <= '0;
      presc <= '0;
    end else begin
      out <= nxt;
      tc <= nxt_tc;
      if (en && !load) dir <= updown;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
      digit <= NDIG'(1) << idx;
      seg <= glyph;
      dp <= dir & (idx == '0);
    end
  end
endmodule

// File: tb/tb_updown_counter_disp.sv
// tb_updown_counter_disp: queued expectations checked by a monitor after each clock edge
module tb_updown_counter_disp;
  logic clk = 0, rst = 0, en = 0, updown = 0, load = 0;
  logic [7:0] load_val = 0;
  logic [7:0] out0, out1;
  logic tc0, tc1, dp0, dp1;
  logic [6:0] seg0, seg1;
  logic [1:0] dig0, dig1;
  int total = 0, bad = 0, cyc = 0, base = 0;
  typedef struct {
    string name;
    int cyc;
    bit dut;
    bit disp;
    logic [7:0] out;
    logic tc;
    logic [6:0] seg;
    logic [1:0] digit;
    logic dp;
  } exp_t;
  exp_t q[$];

  updown_counter_disp #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0), .SCAN_DIV(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
    .out(out0), .tc(tc0), .seg(seg0), .dp(dp0), .digit(dig0));
  updown_counter_disp #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1), .SCAN_DIV(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
    .out(out1), .tc(tc1), .seg(seg1), .dp(dp1), .digit(dig1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [7:0] v);
    @(negedge clk);
    en = e;
    updown = u;
    load = l;
    load_val = v;
  endtask

  task automatic pc(input string nm, input bit d, input logic [7:0] o, input logic t);
    exp_t x;
    x.name = nm; x.cyc = cyc + 1; x.dut = d; x.disp = 0;
    x.out = o; x.tc = t; x.seg = 0; x.digit = 0; x.dp = 0;
    q.push_back(x);
  endtask

  // scan phase after edge n of a release: digit index = ((n-1)/2) mod 2 with SCAN_DIV=2
  task automatic pd_three(input string nm, input logic dir);
    exp_t x;
    int n;
    bit i;
    n = cyc + 1 - base;
    i = ((n - 1) >> 1) & 1;
    x.name = nm; x.cyc = cyc + 1; x.dut = 0; x.disp = 1;
    x.out = 0; x.tc = 0;
    x.seg = i ? 7'b0111111 : 7'b1001111;
    x.digit = i ? 2'b10 : 2'b01;
    x.dp = dir & !i;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) chk({e.name, "_stale"}, e.cyc, cyc);
        else if (e.disp) begin
          chk({e.name, "_seg"}, seg0, e.seg);
          chk({e.name, "_digit"}, dig0, e.digit);
          chk({e.name, "_dp"}, dp0, e.dp);
        end else begin
          chk({e.name, "_out"}, e.dut ? out1 : out0, e.out);
          chk({e.name, "_tc"}, e.dut ? tc1 : tc0, e.tc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_out", out0, 0);
    chk("rst_tc", tc0, 0);
    chk("rst_seg", seg0, 0);
    chk("rst_digit", dig0, 0);
    chk("rst_dp", dp0, 0);
    @(negedge clk);
    rst = 1;
    base = cyc;
    // wrap counting up through MAX_VAL=9
    for (int k = 1; k <= 12; k++) begin
      drive(1, 1, 0, 0);
      pc("up", 0, 8'(k % 10), k == 10);
    end
    // load clamps, then wrap from the clamped value
    drive(1, 1, 1, 200);
    pc("load_clamp", 0, 9, 0);
    drive(1, 1, 0, 0);
    pc("clamp_wrap", 0, 0, 1);
    // wrap counting down from zero
    drive(1, 0, 0, 0);
    pc("down_wrap", 0, 9, 1);
    drive(1, 0, 0, 0);
    pc("down_step", 0, 8, 0);
    // saturating instance holds at the top with tc on every limit step
    drive(0, 1, 1, 9);
    pc("sat_load", 1, 9, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0);
      pc("sat_hold", 1, 9, 1);
    end
    drive(1, 0, 0, 0);
    pc("sat_down", 1, 8, 0);
    // display scan with out=3 reached by an up-count
    drive(0, 0, 1, 2);
    pc("scan_load", 0, 2, 0);
    drive(1, 1, 0, 0);
    pc("scan_up", 0, 3, 0);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 0);
      pd_three("scan", 1);
    end
    // asynchronous reset between edges
    drive(0, 1, 1, 7);
    pc("pre_rst", 0, 7, 0);
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    chk("arst_out", out0, 0);
    chk("arst_seg", seg0, 0);
    chk("arst_digit", dig0, 0);
    chk("arst_dp", dp0, 0);
    chk("arst_out_sat", out1, 0);
    load = 0;
    @(negedge clk);
    rst = 1;
    base = cyc;
    drive(1, 1, 0, 0);
    pc("resume1", 0, 1, 0);
    drive(1, 1, 0, 0);
    pc("resume2", 0, 2, 0);
    drive(0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
